// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: owns the register file's only write port.
// After reset or clr it sweeps INIT_VAL into every register, because the
// register file has no reset of its own. It then shares the port between
// requester 0 (ALU writeback) and requester 1 (load/host path) using a
// round-robin req/gnt handshake. Writes issue one cycle after the grant.
module regfile_wr_arbiter #(
    parameter int                 DATA_W   = 8,
    parameter int                 ADDR_W   = 4,
    parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic [1:0]        req,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] data0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] data1,
    output logic [1:0]        gnt,
    output logic              rf_wrEn,
    output logic [ADDR_W-1:0] rf_wAdd,
    output logic [DATA_W-1:0] rf_wData,
    output logic              init_done
);

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Highest register address; the sweep finishes after writing it.
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              last_q, last_d;   // index of the most recently granted requester
    logic              wrEn_q, wrEn_d;
    logic [ADDR_W-1:0] wAdd_q, wAdd_d;
    logic [DATA_W-1:0] wData_q, wData_d;
    logic              done_q, done_d;

    // Grant: only in RUN, never during reset or a clr cycle; on a tie the
    // requester that did not win last time gets the port.
    always_comb begin
        gnt = 2'b00;
        if (!reset && state_q == S_RUN && !clr) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last_q ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    // Next state: init sweep step, clr restart, or registering a granted write.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        wrEn_d  = 1'b0;
        wAdd_d  = wAdd_q;
        wData_d = wData_q;
        done_d  = done_q;
        case (state_q)
            S_INIT: begin
                wrEn_d  = 1'b1;
                wAdd_d  = cnt_q;
                wData_d = INIT_VAL;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = S_RUN;
                    done_d  = 1'b1;
                end
            end
            S_RUN: begin
                if (clr) begin
                    // The last pointer deliberately survives a clr.
                    state_d = S_INIT;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                end else if (gnt[0]) begin
                    wrEn_d  = 1'b1;
                    wAdd_d  = addr0;
                    wData_d = data0;
                    last_d  = 1'b0;
                end else if (gnt[1]) begin
                    wrEn_d  = 1'b1;
                    wAdd_d  = addr1;
                    wData_d = data1;
                    last_d  = 1'b1;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    // State and write-port registers; reset aborts any pending write.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            wrEn_q  <= 1'b0;
            wAdd_q  <= '0;
            wData_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            wrEn_q  <= wrEn_d;
            wAdd_q  <= wAdd_d;
            wData_q <= wData_d;
            done_q  <= done_d;
        end
    end

    assign rf_wrEn   = wrEn_q;
    assign rf_wAdd   = wAdd_q;
    assign rf_wData  = wData_q;
    assign init_done = done_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural model, with an emulated
// register file behind the write port.
module tb_regfile_wr_arbiter;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int NR = 16;
    localparam logic [DW-1:0] IVAL = 8'h00;

    logic          clk = 1'b0;
    logic          reset, clr;
    logic [1:0]    req;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] data0, data1;
    logic [1:0]    gnt;
    logic          rf_wrEn;
    logic [AW-1:0] rf_wAdd;
    logic [DW-1:0] rf_wData;
    logic          init_done;

    regfile_wr_arbiter #(.DATA_W(DW), .ADDR_W(AW), .INIT_VAL(IVAL)) dut (
        .clk(clk), .reset(reset), .clr(clr), .req(req),
        .addr0(addr0), .data0(data0), .addr1(addr1), .data1(data1),
        .gnt(gnt), .rf_wrEn(rf_wrEn), .rf_wAdd(rf_wAdd),
        .rf_wData(rf_wData), .init_done(init_done)
    );

    always #5 clk = ~clk;

    // Emulated register file: no reset, written from the arbiter's port.
    logic [DW-1:0] rf [NR];
    initial for (int i = 0; i < NR; i++) rf[i] = DW'($urandom);
    always @(posedge clk) if (rf_wrEn) rf[rf_wAdd] <= rf_wData;

    // Behavioural model
    bit            m_init = 1'b1;
    int            m_cnt  = 0;
    int            m_last = 1;
    logic          m_wrEn = 1'b0;
    logic [AW-1:0] m_wAdd = '0;
    logic [DW-1:0] m_wData = '0;
    logic          m_done = 1'b0;
    logic [DW-1:0] mem_exp [NR];

    int   n_chk = 0;
    int   n_fail = 0;
    logic [1:0] last_gnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] model_gnt();
        if (reset || m_init || clr) return 2'b00;
        if (req == 2'b11) return (m_last == 1) ? 2'b01 : 2'b10;
        return req;
    endfunction

    // One clock cycle: compare at the falling edge, advance the model,
    // then return 1 time unit after the rising edge.
    task automatic step();
        logic [1:0] eg;
        @(negedge clk);
        eg = model_gnt();
        chk("gnt", gnt, eg);
        chk("rf_wrEn", rf_wrEn, m_wrEn);
        chk("rf_wAdd", rf_wAdd, m_wAdd);
        chk("rf_wData", rf_wData, m_wData);
        chk("init_done", init_done, m_done);
        last_gnt = gnt;
        if (reset) begin
            m_init = 1; m_cnt = 0; m_last = 1;
            m_wrEn = 0; m_wAdd = '0; m_wData = '0; m_done = 0;
        end else if (m_init) begin
            m_wrEn = 1; m_wAdd = AW'(m_cnt); m_wData = IVAL;
            mem_exp[m_cnt] = IVAL;
            if (m_cnt == NR - 1) begin
                m_init = 0; m_done = 1;
            end
            m_cnt = (m_cnt + 1) % NR;
        end else if (clr) begin
            m_wrEn = 0; m_init = 1; m_cnt = 0; m_done = 0;
        end else if (eg != 2'b00) begin
            int w;
            w = (eg == 2'b01) ? 0 : 1;
            m_wrEn  = 1;
            m_wAdd  = (w == 0) ? addr0 : addr1;
            m_wData = (w == 0) ? data0 : data1;
            mem_exp[m_wAdd] = m_wData;
            m_last = w;
        end else begin
            m_wrEn = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0; clr = 0; req = 2'b00;
    endtask

    task automatic run_until_run();
        int n;
        n = 0;
        while (m_init && n < 40) begin
            step();
            n++;
        end
        chk("reach_run", init_done, 1'b1);
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < NR; i++) chk(tag, rf[i], mem_exp[i]);
    endtask

    logic [1:0] seq3 [4];
    bit         pend0, pend1;

    initial begin
        seq3[0] = 2'b01; seq3[1] = 2'b10; seq3[2] = 2'b01; seq3[3] = 2'b10;
        reset = 1; clr = 0; req = 2'b00;
        addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;

        // 1. reset, then the 16-cycle init sweep
        repeat (3) step();
        chk("reset_wrEn", rf_wrEn, 1'b0);
        chk("reset_done", init_done, 1'b0);
        idle_inputs();
        for (int k = 0; k < NR; k++) begin
            step();
            chk("sweep_wrEn", rf_wrEn, 1'b1);
            chk("sweep_wAdd", rf_wAdd, k);
            chk("sweep_wData", rf_wData, 8'h00);
        end
        chk("sweep_done", init_done, 1'b1);
        step();
        for (int i = 0; i < NR; i++) chk("sweep_zero", rf[i], 8'h00);

        // 2. single write from requester 0
        req = 2'b01; addr0 = 4'd3; data0 = 8'hA5;
        step();
        chk("t2_gnt", last_gnt, 2'b01);
        chk("t2_wrEn", rf_wrEn, 1'b1);
        chk("t2_wAdd", rf_wAdd, 4'd3);
        req = 2'b00;
        step();
        chk("t2_rf3", rf[3], 8'hA5);

        // 3. contention with last=1 alternates 01,10,01,10
        req = 2'b10; addr1 = 4'd1; data1 = 8'h10;
        step();
        for (int k = 0; k < 4; k++) begin
            req = 2'b11;
            addr0 = AW'(4 + k); data0 = DW'(8'h40 + k);
            addr1 = AW'(8 + k); data1 = DW'(8'h80 + k);
            step();
            chk("t3_gnt", last_gnt, seq3[k]);
            chk("t3_wrEn", rf_wrEn, 1'b1);
        end

        // 4. same address from both; later-granted data survives
        req = 2'b11; addr0 = 4'd7; addr1 = 4'd7; data0 = 8'h11; data1 = 8'h22;
        step();
        chk("t4_gnt0", last_gnt, 2'b01);
        req = 2'b10;
        step();
        chk("t4_gnt1", last_gnt, 2'b10);
        chk("t4_rf7a", rf[7], 8'h11);
        req = 2'b00;
        step();
        chk("t4_rf7b", rf[7], 8'h22);

        // 5. clr with a simultaneous request; last pointer survives
        req = 2'b01; addr0 = 4'd2; data0 = 8'h33;
        step();
        req = 2'b10; addr1 = 4'd5; data1 = 8'h55; clr = 1;
        step();
        chk("t5_gnt_clr", last_gnt, 2'b00);
        chk("t5_done", init_done, 1'b0);
        clr = 0;
        for (int k = 0; k < NR; k++) begin
            step();
            chk("t5_gnt_init", last_gnt, 2'b00);
        end
        chk("t5_run", init_done, 1'b1);
        req = 2'b11; addr0 = 4'd6; data0 = 8'h66;
        step();
        chk("t5_gnt_first", last_gnt, 2'b10);
        req = 2'b00;
        step();
        check_mem("t5_mem");

        // 6. reset in INIT cycle 5 and in RUN with a pending grant
        reset = 1;
        step();
        reset = 0;
        repeat (5) step();
        reset = 1;
        step();
        chk("t6_wrEn_a", rf_wrEn, 1'b0);
        reset = 0;
        step();
        chk("t6_restart", rf_wAdd, 4'd0);
        chk("t6_restart_en", rf_wrEn, 1'b1);
        run_until_run();
        req = 2'b01; addr0 = 4'd9; data0 = 8'h5A; reset = 1;
        step();
        chk("t6_gnt", last_gnt, 2'b00);
        chk("t6_wrEn_b", rf_wrEn, 1'b0);
        idle_inputs();
        run_until_run();
        step();
        check_mem("t6_mem");

        // Randomized traffic with held requests, occasional clr and reset
        pend0 = 0; pend1 = 0;
        for (int c = 0; c < 2000; c++) begin
            if (last_gnt[0]) pend0 = 0;
            if (last_gnt[1]) pend1 = 0;
            if (!pend0 && ($urandom % 3 == 0)) begin
                pend0 = 1; addr0 = AW'($urandom); data0 = DW'($urandom);
            end
            if (!pend1 && ($urandom % 3 == 0)) begin
                pend1 = 1; addr1 = AW'($urandom); data1 = DW'($urandom);
            end
            req   = {pend1, pend0};
            clr   = ($urandom % 40 == 0);
            reset = ($urandom % 150 == 0);
            step();
        end
        idle_inputs();
        run_until_run();
        repeat (2) step();
        check_mem("rand_mem");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
        $fatal(1, "watchdog");
    end

endmodule
